// File: rtl/var_dispatch_if.sv
// Dispatcher bundle: run control, descriptor queue head, four worker lanes and the result port.
// slave is the dispatcher side, master is the environment (queue, workers, consumer).
interface var_dispatch_if #(
   parameter int W = 32
) ();
   logic           go;
   logic           busy;
   logic           done;

   logic           q_empty;
   logic [W-1:0]   q_si;
   logic [W-1:0]   q_ei;
   logic [W-1:0]   q_id;
   logic           q_pop;

   logic [3:0]     w_start;
   logic [4*W-1:0] w_si;
   logic [4*W-1:0] w_ei;
   logic [3:0]     w_done;
   logic [4*W-1:0] w_var;
   logic [4*W-1:0] w_mean;

   logic           res_valid;
   logic [W-1:0]   res_id;
   logic [W-1:0]   res_var;
   logic [W-1:0]   res_mean;
   logic           res_ready;

   modport slave (
      input  go, q_empty, q_si, q_ei, q_id, w_done, w_var, w_mean, res_ready,
      output busy, done, q_pop, w_start, w_si, w_ei, res_valid, res_id, res_var, res_mean
   );

   modport master (
      output go, q_empty, q_si, q_ei, q_id, w_done, w_var, w_mean, res_ready,
      input  busy, done, q_pop, w_start, w_si, w_ei, res_valid, res_id, res_var, res_mean
   );
endinterface

// File: rtl/var_dispatch.sv
// Round-robin dispatcher of index-range descriptors to four variance workers with result collection.
// Define VD_INORDER_EN to return results in dispatch order instead of slot order.
module var_dispatch #(
   parameter int W = 32
) (
   input logic           Clk,
   input logic           Rst,
   var_dispatch_if.slave bus
);
   localparam int NW = 4;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} stateT;
   typedef enum logic [1:0] {SLOT_FREE, SLOT_BUSY, SLOT_HELD} slotT;

   stateT         stateReg, stateNext;
   slotT          slotReg [NW];
   logic [W-1:0]  siReg   [NW];
   logic [W-1:0]  eiReg   [NW];
   logic [W-1:0]  idReg   [NW];
   logic [W-1:0]  varReg  [NW];
   logic [W-1:0]  meanReg [NW];
   logic [NW-1:0] startReg;
   logic [1:0]    dpReg;
   logic [1:0]    rpReg;

   logic          resValidReg;
   logic [1:0]    resSlotReg;
   logic [W-1:0]  resIdReg;
   logic [W-1:0]  resVarReg;
   logic [W-1:0]  resMeanReg;

   logic [NW-1:0] freeMask, busyMask, heldMask, eligMask, tagOk;
   logic [NW-1:0] dispOh, capOh, accOh;
   logic          dispFound, selFound;
   logic [1:0]    dispIdx, selIdx, selPtr;
   logic          dispatch, accept, loadRes;

   // First set bit of mask at or after ptr, wrapping; returns {found, index}.
   function automatic logic [2:0] pickRr(input logic [NW-1:0] mask, input logic [1:0] ptr);
      logic [2:0] r;
      logic [1:0] j;
      r = '0;
      for (int i = NW - 1; i >= 0; i--) begin
         j = ptr + 2'(i);
         if (mask[j]) r = {1'b1, j};
      end
      return r;
   endfunction

   for (genvar gi = 0; gi < NW; gi++) begin : gMask
      assign freeMask[gi] = (slotReg[gi] == SLOT_FREE);
      assign busyMask[gi] = (slotReg[gi] == SLOT_BUSY);
      assign heldMask[gi] = (slotReg[gi] == SLOT_HELD);
   end

`ifdef VD_INORDER_EN
   logic [7:0] dSeqReg, oSeqReg, oSeqEff;
   logic [7:0] tagReg [NW];

   // An acceptance this cycle advances the output sequence for a same-edge reload.
   assign oSeqEff = accept ? oSeqReg + 8'd1 : oSeqReg;

   for (genvar gi = 0; gi < NW; gi++) begin : gTag
      assign tagOk[gi] = (tagReg[gi] == oSeqEff);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         dSeqReg <= '0;
         oSeqReg <= '0;
         for (int k = 0; k < NW; k++) tagReg[k] <= '0;
      end else if (stateReg == IDLE && bus.go) begin
         dSeqReg <= '0;
         oSeqReg <= '0;
      end else begin
         if (dispatch) begin
            tagReg[dispIdx] <= dSeqReg;
            dSeqReg         <= dSeqReg + 8'd1;
         end
         if (accept) oSeqReg <= oSeqReg + 8'd1;
      end
   end
`else
   assign tagOk = '1;
`endif

   always_comb begin
      {dispFound, dispIdx} = pickRr(freeMask, dpReg);
      dispatch = Rst && (stateReg == RUN) && !bus.q_empty && dispFound;
      dispOh   = dispatch ? (NW'(1) << dispIdx) : '0;
      capOh    = bus.w_done & busyMask;
      accept   = resValidReg && bus.res_ready;
      accOh    = accept ? (NW'(1) << resSlotReg) : '0;
      // The slot being accepted must not be reloaded; search restarts just past it.
      eligMask = heldMask & ~accOh & tagOk;
      selPtr   = accept ? resSlotReg + 2'd1 : rpReg;
      {selFound, selIdx} = pickRr(eligMask, selPtr);
      loadRes  = (!resValidReg || accept) && selFound;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int k = 0; k < NW; k++) begin
            slotReg[k] <= SLOT_FREE;
            siReg[k]   <= '0;
            eiReg[k]   <= '0;
            idReg[k]   <= '0;
            varReg[k]  <= '0;
            meanReg[k] <= '0;
         end
         startReg <= '0;
      end else begin
         startReg <= dispOh;
         for (int k = 0; k < NW; k++) begin
            if (dispOh[k]) begin
               slotReg[k] <= SLOT_BUSY;
               siReg[k]   <= bus.q_si;
               eiReg[k]   <= bus.q_ei;
               idReg[k]   <= bus.q_id;
            end else if (capOh[k]) begin
               slotReg[k] <= SLOT_HELD;
               varReg[k]  <= bus.w_var[k*W +: W];
               meanReg[k] <= bus.w_mean[k*W +: W];
            end else if (accOh[k]) begin
               slotReg[k] <= SLOT_FREE;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         resValidReg <= 1'b0;
         resSlotReg  <= '0;
         resIdReg    <= '0;
         resVarReg   <= '0;
         resMeanReg  <= '0;
         rpReg       <= '0;
         dpReg       <= '0;
      end else begin
         if (loadRes) begin
            resValidReg <= 1'b1;
            resSlotReg  <= selIdx;
            resIdReg    <= idReg[selIdx];
            resVarReg   <= varReg[selIdx];
            resMeanReg  <= meanReg[selIdx];
         end else if (accept) begin
            resValidReg <= 1'b0;
         end
         if (accept)   rpReg <= resSlotReg + 2'd1;
         if (dispatch) dpReg <= dispIdx + 2'd1;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) stateReg <= IDLE;
      else      stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (bus.go) stateNext = RUN;
         RUN:     if (bus.q_empty) stateNext = DRAIN;
         DRAIN: begin
            if (!bus.q_empty)    stateNext = RUN;
            else if (&freeMask)  stateNext = FIN;
         end
         FIN:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign bus.busy      = (stateReg == RUN) || (stateReg == DRAIN);
   assign bus.done      = (stateReg == FIN);
   assign bus.q_pop     = dispatch;
   assign bus.w_start   = startReg;
   assign bus.res_valid = resValidReg;
   assign bus.res_id    = resIdReg;
   assign bus.res_var   = resVarReg;
   assign bus.res_mean  = resMeanReg;

   for (genvar gi = 0; gi < NW; gi++) begin : gOut
      assign bus.w_si[gi*W +: W] = siReg[gi];
      assign bus.w_ei[gi*W +: W] = eiReg[gi];
   end
endmodule

// File: tb/tb_var_dispatch.sv
// Scoreboard bench for var_dispatch: descriptors and worker results are queued as expectations
// when driven, and checked when the DUT starts a worker or hands over a result.
module tb_var_dispatch;
   localparam int W  = 32;
   localparam int CW = 4 * W;

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   var_dispatch_if #(.W(W)) bus ();
   var_dispatch #(.W(W)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

   typedef struct packed { logic [W-1:0] si; logic [W-1:0] ei; logic [W-1:0] id; } descT;
   typedef struct packed { logic [W-1:0] id; logic [W-1:0] v;  logic [W-1:0] m;  } resT;

   descT         feedQ[$];
   descT         expDispQ[$];
   resT          expResQ[$];
   logic [W-1:0] wkId [4];
   int           startLog[$];
   int           startCyc[$];
   int           accCyc[$];
   int           nTests = 0;
   int           nFail  = 0;
   int           popCnt = 0;
   int           accCnt = 0;
   int           cyc    = 0;

   logic         sBusy, sDone, sQpop, sResValid;
   logic [3:0]   sStart;
   logic [W-1:0] sResId, sResVar, sResMean;

   task automatic checkEq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic pushDesc(input int i);
      descT d;
      d.si = W'(2 * i);
      d.ei = W'(2 * i + 2);
      d.id = W'(i);
      feedQ.push_back(d);
      expDispQ.push_back(d);
   endtask

   // Pulse worker k's completion this cycle; the caller orders calls as results must emerge.
   task automatic doneWork(input int k, input logic [W-1:0] v, input logic [W-1:0] m);
      resT r;
      bus.w_done[k]          = 1'b1;
      bus.w_var[k*W +: W]    = v;
      bus.w_mean[k*W +: W]   = m;
      r.id = wkId[k];
      r.v  = v;
      r.m  = m;
      expResQ.push_back(r);
   endtask

   // One clock cycle: drive queue head, sample at +2, score, apply pop after the edge.
   task automatic tick();
      descT h;
      descT d;
      resT  r;
      bus.q_empty = (feedQ.size() == 0);
      h = (feedQ.size() != 0) ? feedQ[0] : '0;
      bus.q_si = h.si;
      bus.q_ei = h.ei;
      bus.q_id = h.id;
      #2;
      sBusy     = bus.busy;
      sDone     = bus.done;
      sQpop     = bus.q_pop;
      sStart    = bus.w_start;
      sResValid = bus.res_valid;
      sResId    = bus.res_id;
      sResVar   = bus.res_var;
      sResMean  = bus.res_mean;
      if (bus.q_empty) checkEq("q_pop_when_empty", bus.q_pop, 0);
      if (bus.q_pop) popCnt++;
      for (int k = 0; k < 4; k++) begin
         if (bus.w_start[k]) begin
            startLog.push_back(k);
            startCyc.push_back(cyc);
            if (expDispQ.size() == 0) begin
               checkEq("w_start_unexpected", bus.w_start[k], 0);
            end else begin
               d = expDispQ.pop_front();
               $display("[TB] cyc %0d start slot %0d si=%0h ei=%0h id=%0h", cyc, k,
                        bus.w_si[k*W +: W], bus.w_ei[k*W +: W], d.id);
               checkEq("w_si", bus.w_si[k*W +: W], d.si);
               checkEq("w_ei", bus.w_ei[k*W +: W], d.ei);
               wkId[k] = d.id;
            end
         end
      end
      if (bus.res_valid && bus.res_ready) begin
         accCnt++;
         accCyc.push_back(cyc);
         $display("[TB] cyc %0d result id=%0h var=%0h mean=%0h", cyc,
                  bus.res_id, bus.res_var, bus.res_mean);
         if (expResQ.size() == 0) begin
            checkEq("res_unexpected", bus.res_valid, 0);
         end else begin
            r = expResQ.pop_front();
            checkEq("res_id", bus.res_id, r.id);
            checkEq("res_var", bus.res_var, r.v);
            checkEq("res_mean", bus.res_mean, r.m);
         end
      end
      @(posedge Clk);
      if (sQpop && feedQ.size() != 0) feedQ.delete(0);
      @(negedge Clk);
      cyc++;
      bus.go     = 1'b0;
      bus.w_done = '0;
   endtask

   task automatic doReset();
      Rst         = 1'b0;
      bus.q_empty = 1'b0;
      bus.q_si    = W'(7);
      bus.q_ei    = W'(9);
      bus.q_id    = W'(5);
      #2;
      checkEq("rst_busy", bus.busy, 0);
      checkEq("rst_done", bus.done, 0);
      checkEq("rst_q_pop", bus.q_pop, 0);
      checkEq("rst_w_start", bus.w_start, 0);
      checkEq("rst_w_si", bus.w_si, 0);
      checkEq("rst_w_ei", bus.w_ei, 0);
      checkEq("rst_res_valid", bus.res_valid, 0);
      checkEq("rst_res_id", bus.res_id, 0);
      checkEq("rst_res_var", bus.res_var, 0);
      checkEq("rst_res_mean", bus.res_mean, 0);
      @(negedge Clk);
      Rst = 1'b1;
      feedQ.delete();
      expDispQ.delete();
      expResQ.delete();
      startLog.delete();
      startCyc.delete();
      accCyc.delete();
      popCnt = 0;
      accCnt = 0;
      bus.go        = 1'b0;
      bus.w_done    = '0;
      bus.res_ready = 1'b0;
   endtask

   task automatic waitDone(input int bound);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         tick();
         if (sDone) seen = 1'b1;
      end
      checkEq("done_seen", seen, 1);
      checkEq("res_drained", expResQ.size(), 0);
   endtask

   initial begin
      int doneCnt;
      int doneAt;
      int ghost;
      bus.go = 1'b0;  bus.q_empty = 1'b1;
      bus.q_si = '0;  bus.q_ei = '0;  bus.q_id = '0;
      bus.w_done = '0; bus.w_var = '0; bus.w_mean = '0;
      bus.res_ready = 1'b0;
      doReset();

      // Empty queue: RUN, DRAIN, FIN; single done three cycles after go.
      doneCnt = 0;
      doneAt  = -1;
      bus.go  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (sDone) begin doneCnt++; doneAt = i; end
         if (i == 1 || i == 2) checkEq("empty_busy", sBusy, 1);
         if (i == 3) checkEq("fin_not_busy", sBusy, 0);
      end
      checkEq("empty_done_count", doneCnt, 1);
      checkEq("empty_done_cycle", doneAt, 3);

      // Three descriptors go to slots 0,1,2 on successive cycles.
      doReset();
      for (int i = 0; i < 3; i++) pushDesc(i);
      bus.go = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      checkEq("rr_pop_count", popCnt, 3);
      checkEq("rr_start_count", startLog.size(), 3);
      for (int i = 0; i < 3 && i < startLog.size(); i++) checkEq("rr_start_slot", startLog[i], i);
      if (startCyc.size() >= 3) checkEq("rr_start_spacing", startCyc[2] - startCyc[0], 2);
      bus.res_ready = 1'b1;
      doneWork(0, 'h100, 'h10);
      doneWork(1, 'h101, 'h11);
      doneWork(2, 'h102, 'h12);
      tick();
      waitDone(30);
      checkEq("rr_acc_count", accCnt, 3);

      // Six descriptors, workers never finish: exactly four pops.
      doReset();
      for (int i = 0; i < 6; i++) pushDesc(i);
      bus.go = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      checkEq("full_pop_count", popCnt, 4);
      checkEq("full_start_count", startLog.size(), 4);
      checkEq("full_busy", sBusy, 1);

      // Held result stays stable under backpressure; slot redispatches only after acceptance.
      doneWork(2, 'h10, 'h5);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checkEq("hold_valid", sResValid, 1);
         checkEq("hold_id", sResId, 2);
         checkEq("hold_var", sResVar, 'h10);
         checkEq("hold_mean", sResMean, 'h5);
         checkEq("hold_no_pop", sQpop, 0);
      end
      accCnt = 0;
      bus.res_ready = 1'b1;
      tick();
      checkEq("hold_accept", accCnt, 1);
      checkEq("no_pop_on_accept", sQpop, 0);
      bus.res_ready = 1'b0;
      tick();
      checkEq("pop_after_accept", sQpop, 1);
      checkEq("valid_drops", sResValid, 0);
      tick();
      checkEq("redispatch_slot2", sStart, 4'b0100);

      // Two completions in one cycle: back-to-back results in slot order 1 then 3.
      doReset();
      for (int i = 0; i < 4; i++) pushDesc(i);
      bus.go = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      checkEq("pair_start_count", startLog.size(), 4);
      bus.res_ready = 1'b1;
      doneWork(1, 'h11, 'h21);
      doneWork(3, 'h13, 'h23);
      tick();
      for (int i = 0; i < 4; i++) tick();
      checkEq("pair_acc_count", accCnt, 2);
      if (accCyc.size() >= 2) checkEq("pair_back_to_back", accCyc[1] - accCyc[0], 1);
      doneWork(0, 'h10, 'h20);
      doneWork(2, 'h12, 'h22);
      tick();
      waitDone(30);

      // Reset mid-run discards busy and held slots; later completions are ignored.
      doReset();
      for (int i = 0; i < 3; i++) pushDesc(i);
      bus.go = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      doneWork(2, 'h30, 'h31);
      tick();
      tick();
      tick();
      checkEq("pre_rst_valid", sResValid, 1);
      doReset();
      bus.res_ready = 1'b1;
      bus.w_done    = 4'b0011;
      ghost = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (sResValid || sStart != 4'b0000 || sBusy) ghost++;
      end
      checkEq("post_rst_quiet", ghost, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
